// File: rtl/token_div_pkg.sv
// Shared constants, types and helpers for the token divider.
// Holds default parameters, the count type and a saturating increment.
package token_div_pkg;

  localparam int CH_DEF     = 4;
  localparam int DIV_W_DEF  = 4;
  localparam int STAT_W_DEF = 8;

  typedef logic [DIV_W_DEF-1:0] cnt_t;

  // Increment v, holding at 2^w-1 (w up to 32).
  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input int          w
  );
    logic [32:0] mx;
    mx = (33'd1 << w) - 33'd1;
    if ({1'b0, v} >= mx) return v;
    return v + 32'd1;
  endfunction

endpackage

// File: rtl/token_div_channel.sv
// One token-divider channel: passes every Nth token, drops the rest.
// Ports: clk, rst, a (token), clr, div (N), b (passed token), drop_cnt (TOKEN_DIV_STATS_EN).
module token_div_channel
  import token_div_pkg::*;
#(
  parameter int DIV_W  = DIV_W_DEF
`ifdef TOKEN_DIV_STATS_EN
  ,
  parameter int STAT_W = STAT_W_DEF
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             b
`ifdef TOKEN_DIV_STATS_EN
  ,
  output logic [STAT_W-1:0] drop_cnt
`endif
);

  logic [DIV_W-1:0] cnt;
  logic             pass;

  // >= rather than == so a shrinking N releases the next token at once.
  always_comb begin
    pass = 1'b1;
    if (clr) begin
      pass = 1'b0;
    end else if (div > DIV_W'(1)) begin
      pass = (cnt >= div - DIV_W'(1));
    end
  end

  assign b = a & pass & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (a) begin
      cnt <= pass ? '0 : cnt + DIV_W'(1);
    end
  end

`ifdef TOKEN_DIV_STATS_EN
  logic [STAT_W-1:0] drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop <= '0;
    end else if (a && !b) begin
      drop <= STAT_W'(sat_inc(32'(drop), STAT_W));
    end
  end

  assign drop_cnt = drop;
`endif

endmodule

// File: rtl/halve_tokens_n.sv
// CH-channel token divider: each channel passes one token in every N.
// Ports: clk, rst, a[CH], div, clr[CH], b[CH]; drop_cnt only with TOKEN_DIV_STATS_EN.
module halve_tokens_n
  import token_div_pkg::*;
#(
  parameter int CH     = CH_DEF,
  parameter int DIV_W  = DIV_W_DEF,
  parameter int STAT_W = STAT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    a,
  input  logic [DIV_W-1:0] div,
  input  logic [CH-1:0]    clr,
  output logic [CH-1:0]    b
`ifdef TOKEN_DIV_STATS_EN
  ,
  output logic [CH*STAT_W-1:0] drop_cnt
`endif
);

  if (CH < 1 || CH > 32) begin : g_bad_ch
    $error("CH out of range 1..32");
  end

  if (DIV_W < 1) begin : g_bad_div
    $error("DIV_W must be positive");
  end

  if (STAT_W < 1 || STAT_W > 32) begin : g_bad_stat
    $error("STAT_W out of range 1..32");
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    token_div_channel #(
      .DIV_W  (DIV_W)
`ifdef TOKEN_DIV_STATS_EN
      ,
      .STAT_W (STAT_W)
`endif
    ) u_ch (
      .clk (clk),
      .rst (rst),
      .a   (a[i]),
      .clr (clr[i]),
      .div (div),
      .b   (b[i])
`ifdef TOKEN_DIV_STATS_EN
      ,
      .drop_cnt (drop_cnt[i*STAT_W +: STAT_W])
`endif
    );
  end

endmodule

// File: tb/tb_halve_tokens_n.sv
// Scoreboard bench for halve_tokens_n with a token-count reference model.
// Drop counters are checked only when TOKEN_DIV_STATS_EN is defined.
module tb_halve_tokens_n;

  localparam int CH = 4;
  localparam int DW = 4;
  localparam int SW = 2;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] a   = '0;
  logic [CH-1:0] clr = '0;
  logic [DW-1:0] div = '0;
  logic [CH-1:0] b;
`ifdef TOKEN_DIV_STATS_EN
  logic [CH*SW-1:0] drop_cnt;
`endif

  halve_tokens_n #(
    .CH     (CH),
    .DIV_W  (DW),
    .STAT_W (SW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .div (div),
    .clr (clr),
    .b   (b)
`ifdef TOKEN_DIV_STATS_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH-1:0]    b;
    logic [CH*SW-1:0] drop;
    bit               chk_drop;
  } exp_t;

  exp_t          sbq[$];
  logic [CH-1:0] obs[$];
  int checks   = 0;
  int failures = 0;

  // Model: tokens counted since the last passed token, and drops seen.
  int m_cnt [CH];
  int m_drop[CH];
  bit drop_known = 0;

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      obs.push_back(b);
      checks++;
      if (b !== e.b) begin
        failures++;
        $display("FAIL b: got %b want %b at %0t", b, e.b, $time);
      end
`ifdef TOKEN_DIV_STATS_EN
      if (e.chk_drop) begin
        checks++;
        if (drop_cnt !== e.drop) begin
          failures++;
          $display("FAIL drop_cnt: got %h want %h at %0t",
                   drop_cnt, e.drop, $time);
        end
      end
`endif
    end
  end

  task automatic step(input logic [CH-1:0] av, input logic [CH-1:0] cv,
                      input logic [DW-1:0] dv, input logic r);
    exp_t e;
    bit   p;
    @(posedge clk);
    #1;
    a = av; clr = cv; div = dv; rst = r;
    e.b = '0;
    e.drop = '0;
    e.chk_drop = drop_known;
    for (int i = 0; i < CH; i++) begin
      e.drop[i*SW +: SW] = SW'(m_drop[i]);
      if (cv[i]) p = 0;
      else if (dv <= 1) p = 1;
      else p = (m_cnt[i] >= int'(dv) - 1);
      e.b[i] = !r && av[i] && p;
      if (r) begin
        m_cnt[i]  = 0;
        m_drop[i] = 0;
      end else begin
        if (av[i] && !p)
          m_drop[i] = (m_drop[i] < SMAX) ? m_drop[i] + 1 : SMAX;
        if (cv[i]) m_cnt[i] = 0;
        else if (av[i]) m_cnt[i] = p ? 0 : m_cnt[i] + 1;
      end
    end
    if (r) drop_known = 1;
    sbq.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sbq.size() > 0 && n < 20);
    #1;
    a = '0;
    clr = '0;
    checks++;
    if (sbq.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d pending want 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic begin_scn();
    drain();
    obs.delete();
  endtask

  task automatic check_seq(input string nm, input int ch,
                           input logic [31:0] want, input int len);
    logic [31:0] got;
    got = '0;
    checks++;
    if (obs.size() != len) begin
      failures++;
      $display("FAIL %s: got %0d samples want %0d", nm, obs.size(), len);
    end else begin
      for (int k = 0; k < len; k++) got[len-1-k] = obs[k][ch];
      if (got !== want) begin
        failures++;
        $display("FAIL %s: got %b want %b", nm, got, want);
      end
    end
  endtask

  initial begin
    logic [15:0] seq;
    logic [DW-1:0] dv;
    for (int i = 0; i < CH; i++) begin
      m_cnt[i] = 0;
      m_drop[i] = 0;
    end

    // Reset with random tokens: b must stay low.
    for (int k = 0; k < 3; k++) step(CH'($urandom), '0, DW'(2), 1'b1);
    begin_scn();

    // N=2 on channel 0 from reset.
    seq = 16'b1100111010001111;
    for (int k = 0; k < 16; k++)
      step({3'b000, seq[15-k]}, '0, DW'(2), 1'b0);
    drain();
    check_seq("n2_seq", 0, 32'(16'b0100010010000101), 16);
    check_seq("n2_other", 1, 32'd0, 16);

    // N=3, channel 1 held high for 9 cycles.
    step('0, '0, DW'(3), 1'b1);
    begin_scn();
    for (int k = 0; k < 9; k++) step(4'b0010, '0, DW'(3), 1'b0);
    drain();
    check_seq("n3_hold", 1, 32'(9'b001001001), 9);

    // N=0 then N=1: everything passes.
    begin_scn();
    for (int k = 0; k < 20; k++) step(CH'($urandom), '0, DW'(0), 1'b0);
    for (int k = 0; k < 20; k++) step(CH'($urandom), '0, DW'(1), 1'b0);
    drain();

    // N=4, two tokens, then N=2.
    step('0, '0, DW'(4), 1'b1);
    begin_scn();
    step(4'b0001, '0, DW'(4), 1'b0);
    step(4'b0001, '0, DW'(4), 1'b0);
    for (int k = 0; k < 5; k++) step(4'b0001, '0, DW'(2), 1'b0);
    drain();
    check_seq("div_shrink", 0, 32'(7'b0010101), 7);

    // N=3, two tokens, clear with a token, three more.
    step('0, '0, DW'(3), 1'b1);
    begin_scn();
    step(4'b0100, '0, DW'(3), 1'b0);
    step(4'b0100, '0, DW'(3), 1'b0);
    step(4'b0100, 4'b0100, DW'(3), 1'b0);
    for (int k = 0; k < 3; k++) step(4'b0100, '0, DW'(3), 1'b0);
    drain();
    check_seq("clr_drop", 2, 32'(6'b000001), 6);

    // N=4, 20 tokens on channel 3; drop counter saturates, reset clears.
    step('0, '0, DW'(4), 1'b1);
    begin_scn();
    for (int k = 0; k < 20; k++) step(4'b1000, '0, DW'(4), 1'b0);
    step('0, '0, DW'(4), 1'b1);
    step('0, '0, DW'(4), 1'b0);
    step('0, '0, DW'(4), 1'b0);
    drain();

    // Random mix of tokens, clears, ratio changes and resets.
    dv = DW'($urandom_range(0, 15));
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 9) == 0) dv = DW'($urandom_range(0, 15));
      step(CH'($urandom),
           ($urandom_range(0, 7) == 0) ? CH'($urandom) : '0,
           dv,
           $urandom_range(0, 99) == 0);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
